// File: rtl/servo_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servo_motion_ctrl
// Brief    : Shared-frame PWM for arm/marble servos with out/hold/back motion
//            sequencing and a single arm-priority motion grant.
// Option   : SERVO_PWM_IDLE_OFF_EN - no pulses while a channel is IDLE/DONE
// Revision : 1.0 - initial release
// ============================================================================
module servo_motion_ctrl #(
  parameter int FRAME_CYCLES = 2_000_000,
  parameter int MIN_PW       = 100_000,
  parameter int MAX_PW       = 200_000,
  parameter int STEP_PW      = 10_000,
  parameter int HOLD_FRAMES  = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_servo_arm,
  input  logic reset_servo_arm,
  input  logic enable_servo_marble,
  input  logic reset_servo_marble,
  output logic pwm_arm,
  output logic pwm_marble,
  output logic done_servo_arm,
  output logic done_servo_marble,
  output logic busy
);

  localparam int W  = $clog2(FRAME_CYCLES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [W-1:0]  c_frame_last = W'(FRAME_CYCLES - 1);
  localparam logic [W-1:0]  c_min_pw     = W'(MIN_PW);
  localparam logic [W-1:0]  c_max_pw     = W'(MAX_PW);
  localparam logic [W-1:0]  c_step_pw    = W'(STEP_PW);
  localparam logic [HW-1:0] c_hold_last  = HW'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SWEEP_OUT  = 3'd1,
    S_HOLD       = 3'd2,
    S_SWEEP_BACK = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  logic [W-1:0]  r_frame_cnt;
  logic          w_wrap;

  state_t        r_state    [2];
  state_t        w_state_nxt[2];
  logic [W-1:0]  r_pw       [2];
  logic [W-1:0]  w_pw_nxt   [2];
  logic [HW-1:0] r_hold     [2];
  logic [HW-1:0] w_hold_nxt [2];

  logic [1:0]    r_pwm;
  logic [1:0]    w_en;
  logic [1:0]    w_clr;
  logic [1:0]    w_moving;
  logic [1:0]    w_drive;
  logic [1:0]    w_take;
  logic          w_grant_free;

  // Channel index 0 is the arm, 1 is the marble.
  assign w_en   = {enable_servo_marble, enable_servo_arm};
  assign w_clr  = {reset_servo_marble, reset_servo_arm};
  assign w_wrap = (r_frame_cnt == c_frame_last);

  always_ff @(posedge clk) begin
    if (rst || w_wrap) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // The grant is implied by a channel being mid-motion, so it cannot drift
  // out of step with the channel states.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      assign w_moving[g] = (r_state[g] == S_SWEEP_OUT) ||
                           (r_state[g] == S_HOLD)      ||
                           (r_state[g] == S_SWEEP_BACK);
`ifdef SERVO_PWM_IDLE_OFF_EN
      assign w_drive[g] = w_moving[g];
`else
      assign w_drive[g] = 1'b1;
`endif
    end
  endgenerate

  assign w_grant_free = ~|w_moving;

  // Current states are used, so a release and a new grant never share a wrap.
  assign w_take[0] = w_wrap && w_grant_free && (r_state[0] == S_IDLE) &&
                     w_en[0] && !w_clr[0];
  assign w_take[1] = w_wrap && w_grant_free && (r_state[1] == S_IDLE) &&
                     w_en[1] && !w_clr[1] && !w_take[0];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_pw_nxt[i]    = r_pw[i];
      w_hold_nxt[i]  = r_hold[i];
      if (w_clr[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_pw_nxt[i]    = c_min_pw;
        w_hold_nxt[i]  = '0;
      end else if (w_wrap) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_take[i]) w_state_nxt[i] = S_SWEEP_OUT;
          end
          S_SWEEP_OUT: begin
            w_pw_nxt[i] = r_pw[i] + c_step_pw;
            if (r_pw[i] + c_step_pw == c_max_pw) begin
              w_state_nxt[i] = S_HOLD;
              w_hold_nxt[i]  = '0;
            end
          end
          S_HOLD: begin
            if (r_hold[i] == c_hold_last) begin
              w_state_nxt[i] = S_SWEEP_BACK;
            end else begin
              w_hold_nxt[i] = r_hold[i] + 1'b1;
            end
          end
          S_SWEEP_BACK: begin
            w_pw_nxt[i] = r_pw[i] - c_step_pw;
            if (r_pw[i] - c_step_pw == c_min_pw) w_state_nxt[i] = S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        r_state[i] <= S_IDLE;
        r_pw[i]    <= c_min_pw;
        r_hold[i]  <= '0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_pw[i]    <= w_pw_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end
    end
  end

  // Width registers only move at wrap, where frame_cnt is past any legal width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_pwm[i] <= w_drive[i] && (r_frame_cnt < r_pw[i]);
      end
    end
  end

  assign pwm_arm           = r_pwm[0];
  assign pwm_marble        = r_pwm[1];
  assign done_servo_arm    = (r_state[0] == S_DONE);
  assign done_servo_marble = (r_state[1] == S_DONE);
  assign busy              = |w_moving;

endmodule
`default_nettype wire
